// File: rtl/core_ctrl.sv
// Sequencing controller for the systolic core: loads activations/weights into xmem,
// stages them through L0, runs the array and drains psums into pmem.
module core_ctrl #(
  parameter int N_ACT = 36,
  parameter int N_W   = 8,
  parameter int N_OUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] host_data,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic [31:0] D_xmem,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, ACT_LD, W_LD, W_L0, KLOAD, ACT_L0, EXEC, DRAIN, FIN
  } state_t;

  localparam int CW = 11;
  localparam logic [CW-1:0] L_ACT = CW'(N_ACT);
  localparam logic [CW-1:0] L_W   = CW'(N_W);
  localparam logic [CW-1:0] L_OUT = CW'(N_OUT);
  localparam logic [CW-1:0] W_BASE = 11'h400;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nextCnt;
  logic [CW-1:0] w_cntAfter;
  logic          r_pend;
  logic          w_nextPend;
  logic [33:0]   w_nextInst;
  logic [31:0]   w_nextData;
  logic          w_nextDone;
  logic          w_accept;

  assign host_ready = ((r_state == ACT_LD) && (r_cnt < L_ACT)) ||
                      ((r_state == W_LD)   && (r_cnt < L_W));
  assign w_accept   = host_valid && host_ready;
  // r_pend marks an ofifo_rd issued last cycle whose pmem write is due now
  assign w_cntAfter = r_cnt + {{(CW-1){1'b0}}, r_pend};

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextPend  = 1'b0;
    w_nextInst  = IDLE_INST;
    w_nextData  = D_xmem;
    w_nextDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = ACT_LD;
          w_nextCnt   = '0;
        end
      end
      ACT_LD: begin
        if (w_accept) begin
          w_nextInst[19]   = 1'b0;
          w_nextInst[18]   = 1'b0;
          w_nextInst[17:7] = r_cnt;
          w_nextData       = host_data;
          if (r_cnt == L_ACT - 1'b1) begin
            w_nextState = W_LD;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + 1'b1;
          end
        end
      end
      W_LD: begin
        if (w_accept) begin
          w_nextInst[19]   = 1'b0;
          w_nextInst[18]   = 1'b0;
          w_nextInst[17:7] = W_BASE + r_cnt;
          w_nextData       = host_data;
          if (r_cnt == L_W - 1'b1) begin
            w_nextState = W_L0;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + 1'b1;
          end
        end
      end
      W_L0: begin
        if (r_cnt < L_W) begin
          w_nextInst[19]   = 1'b0;
          w_nextInst[17:7] = W_BASE + r_cnt;
        end
        w_nextInst[2] = (r_cnt != '0);
        if (r_cnt == L_W) begin
          w_nextState = KLOAD;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      KLOAD: begin
        if (r_cnt < L_W) begin
          w_nextInst[3] = 1'b1;
          w_nextInst[0] = 1'b1;
          w_nextCnt     = r_cnt + 1'b1;
        end else begin
          w_nextState = ACT_L0;
          w_nextCnt   = '0;
        end
      end
      ACT_L0: begin
        if (r_cnt < L_ACT) begin
          w_nextInst[19]   = 1'b0;
          w_nextInst[17:7] = r_cnt;
        end
        w_nextInst[2] = (r_cnt != '0);
        if (r_cnt == L_ACT) begin
          w_nextState = EXEC;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      EXEC: begin
        w_nextInst[3] = 1'b1;
        w_nextInst[1] = 1'b1;
        if (r_cnt == L_ACT - 1'b1) begin
          w_nextState = DRAIN;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (r_pend) begin
          w_nextInst[33]    = 1'b0;
          w_nextInst[32]    = 1'b0;
          w_nextInst[31]    = 1'b0;
          w_nextInst[30:20] = r_cnt;
        end
        if (ofifo_valid && (w_cntAfter < L_OUT)) begin
          w_nextInst[6] = 1'b1;
          w_nextPend    = 1'b1;
        end
        w_nextCnt = w_cntAfter;
        if (r_cnt == L_OUT) begin
          w_nextState = FIN;
          w_nextCnt   = '0;
        end
      end
      FIN: begin
        w_nextDone  = 1'b1;
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      inst    <= IDLE_INST;
      D_xmem  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_pend  <= w_nextPend;
      inst    <= w_nextInst;
      D_xmem  <= w_nextData;
      busy    <= (w_nextState != IDLE);
      done    <= w_nextDone;
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: table of run scenarios checked against a
// transaction-level model of what a complete run must produce, plus reset sequences.
module tb_core_ctrl;
  localparam int N_ACT = 36;
  localparam int N_W   = 8;
  localparam int N_OUT = 16;
  localparam logic [33:0] IDLE_WORD = (34'd1 << 32) | (34'd1 << 31) | (34'd1 << 19) | (34'd1 << 18);

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic [31:0] D_xmem;
  logic        busy;
  logic        done;

  core_ctrl #(.N_ACT(N_ACT), .N_W(N_W), .N_OUT(N_OUT)) dut (
    .clk(clk), .reset(reset), .start(start), .host_data(host_data),
    .host_valid(host_valid), .host_ready(host_ready), .ofifo_valid(ofifo_valid),
    .inst(inst), .D_xmem(D_xmem), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // validMode: 0 host always valid, 1 toggling, 2 random (also randomizes ofifo_valid)
  typedef struct {
    int validMode;
    bit dataGap;
    bit startInWld;
    int expWrites;
    int expLoads;
    int expExecs;
    int expPmem;
    int expDone;
  } vec_t;
  vec_t vecs[6];

  int          cyc = 0;
  int          wrAddr[$];
  logic [31:0] wrData[$];
  logic [31:0] accepted[$];
  int          rdCyc[$];
  int          rdAddr[$];
  int          l0wCyc[$];
  int          pmemAddr[$];
  int          pmemCyc[$];
  int          ofrdCyc[$];
  int          loadCnt, execCnt, overlap, loadAfterExec, illegalRd, hrViol, badIdle, doneCnt;
  bit          prevOfValid = 1'b0;

  // Output monitor: decodes the registered inst word into transaction logs
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (host_valid && host_ready) accepted.push_back(host_data);
      if (!inst[19] && !inst[18]) begin
        wrAddr.push_back(int'(inst[17:7]));
        wrData.push_back(D_xmem);
        if (!host_ready && wrAddr.size() < N_ACT + N_W) hrViol++;
      end
      if (!inst[19] && inst[18]) begin
        rdCyc.push_back(cyc);
        rdAddr.push_back(int'(inst[17:7]));
      end
      if (inst[2]) l0wCyc.push_back(cyc);
      if (inst[0]) begin
        loadCnt++;
        if (execCnt > 0) loadAfterExec++;
      end
      if (inst[1]) execCnt++;
      if (inst[0] && inst[1]) overlap++;
      if (inst[3] != (inst[0] || inst[1])) badIdle++;
      if (!inst[32] && !inst[31]) begin
        pmemAddr.push_back(int'(inst[30:20]));
        pmemCyc.push_back(cyc);
      end
      if (inst[6]) begin
        ofrdCyc.push_back(cyc);
        if (!prevOfValid) illegalRd++;
      end
      if (inst[33] || inst[5] || inst[4]) badIdle++;
      if (inst[19] && (!inst[18] || inst[17:7] != 11'd0)) badIdle++;
      if (inst[32] && (!inst[31] || inst[30:20] != 11'd0)) badIdle++;
      if (done) doneCnt++;
    end
    prevOfValid = ofifo_valid;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearLogs();
    wrAddr.delete(); wrData.delete(); accepted.delete();
    rdCyc.delete(); rdAddr.delete(); l0wCyc.delete();
    pmemAddr.delete(); pmemCyc.delete(); ofrdCyc.delete();
    loadCnt = 0; execCnt = 0; overlap = 0; loadAfterExec = 0;
    illegalRd = 0; hrViol = 0; badIdle = 0; doneCnt = 0;
  endtask

  // Runs one complete job and compares its transaction logs with the expected run shape
  task automatic applyStimulus(input vec_t v);
    int budget, gapLeft, expA;
    int badA, badD, badR, badT, badL, badP, badC;
    bit gapDone, startSent;
    clearLogs();
    @(posedge clk); #1;
    start = 1'b1; host_valid = 1'b0; ofifo_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busyAfterStart", busy, 1);
    budget = 0; gapLeft = 0; gapDone = 0; startSent = 0;
    while (doneCnt == 0 && budget < 3000) begin
      case (v.validMode)
        0: host_valid = 1'b1;
        1: host_valid = ~host_valid;
        default: host_valid = ($urandom_range(0, 2) != 0);
      endcase
      host_data = $urandom;
      if (v.startInWld && !startSent && accepted.size() == N_ACT + 2) begin
        start = 1'b1;
        startSent = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (v.dataGap && !gapDone && ofrdCyc.size() == 4) begin
        gapLeft = 5;
        gapDone = 1'b1;
      end
      if (gapLeft > 0) begin
        ofifo_valid = 1'b0;
        gapLeft--;
      end else if (v.validMode == 2) begin
        ofifo_valid = ($urandom_range(0, 3) != 0);
      end else begin
        ofifo_valid = 1'b1;
      end
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("runTimeout", budget < 3000, 1);
    start = 1'b0; host_valid = 1'b0; ofifo_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    if (v.startInWld) checkOutput("startInWldSeen", startSent, 1);

    badA = 0; badD = 0; badR = 0; badT = 0; badL = 0; badP = 0; badC = 0;
    checkOutput("writeCount", wrAddr.size(), v.expWrites);
    checkOutput("acceptCount", accepted.size(), v.expWrites);
    for (int i = 0; i < wrAddr.size(); i++) begin
      expA = (i < N_ACT) ? i : 'h400 + i - N_ACT;
      if (wrAddr[i] != expA) badA++;
      if (i < accepted.size() && wrData[i] !== accepted[i]) badD++;
    end
    checkOutput("writeAddrOrder", badA, 0);
    checkOutput("writeDataOrder", badD, 0);
    checkOutput("readCount", rdAddr.size(), N_W + N_ACT);
    for (int i = 0; i < rdAddr.size(); i++) begin
      expA = (i < N_W) ? 'h400 + i : i - N_W;
      if (rdAddr[i] != expA) badR++;
    end
    checkOutput("readAddrOrder", badR, 0);
    for (int i = 0; i < N_W && i < rdCyc.size(); i++)
      if (rdCyc[i] != rdCyc[0] + i) badT++;
    checkOutput("wReadTrain", badT, 0);
    checkOutput("l0wrCount", l0wCyc.size(), rdCyc.size());
    for (int i = 0; i < l0wCyc.size() && i < rdCyc.size(); i++)
      if (l0wCyc[i] != rdCyc[i] + 1) badL++;
    checkOutput("l0wrLag", badL, 0);
    checkOutput("loadCycles", loadCnt, v.expLoads);
    checkOutput("execCycles", execCnt, v.expExecs);
    checkOutput("loadExecOverlap", overlap, 0);
    checkOutput("loadAfterExec", loadAfterExec, 0);
    checkOutput("pmemCount", pmemAddr.size(), v.expPmem);
    checkOutput("ofifoRdCount", ofrdCyc.size(), v.expPmem);
    for (int i = 0; i < pmemAddr.size(); i++) begin
      if (pmemAddr[i] != i) badP++;
      if (i < ofrdCyc.size() && pmemCyc[i] != ofrdCyc[i] + 1) badC++;
    end
    checkOutput("pmemAddrOrder", badP, 0);
    checkOutput("pmemAfterRd", badC, 0);
    checkOutput("rdWithoutValid", illegalRd, 0);
    checkOutput("writeNotReady", hrViol, 0);
    checkOutput("idleFields", badIdle, 0);
    checkOutput("donePulses", doneCnt, v.expDone);
    checkOutput("busyEnd", busy, 0);
    checkOutput("instEnd", inst, IDLE_WORD);
  endtask

  initial begin
    int budget;
    vecs[0] = '{0, 1'b0, 1'b0, N_ACT + N_W, N_W, N_ACT, N_OUT, 1};
    vecs[1] = '{1, 1'b0, 1'b0, N_ACT + N_W, N_W, N_ACT, N_OUT, 1};
    vecs[2] = '{0, 1'b1, 1'b0, N_ACT + N_W, N_W, N_ACT, N_OUT, 1};
    vecs[3] = '{0, 1'b0, 1'b1, N_ACT + N_W, N_W, N_ACT, N_OUT, 1};
    vecs[4] = '{2, 1'b1, 1'b0, N_ACT + N_W, N_W, N_ACT, N_OUT, 1};
    vecs[5] = '{2, 1'b0, 1'b1, N_ACT + N_W, N_W, N_ACT, N_OUT, 1};

    reset = 1'b1; start = 1'b0; host_data = '0; host_valid = 1'b0; ofifo_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetInst", inst, IDLE_WORD);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetDxmem", D_xmem, 0);
    checkOutput("resetHostReady", host_ready, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] scenario %0d", i);
      applyStimulus(vecs[i]);
    end

    // Asynchronous reset in the middle of EXEC, then no resume and a clean restart
    clearLogs();
    @(posedge clk); #1;
    start = 1'b1; host_valid = 1'b1; ofifo_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    while (execCnt < 5 && budget < 2000) begin
      host_data = $urandom;
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("reachExec", execCnt >= 5, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midResetInst", inst, IDLE_WORD);
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetDone", done, 0);
    checkOutput("midResetDxmem", D_xmem, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    clearLogs();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("noResumeBusy", busy, 0);
    checkOutput("noResumeWrites", wrAddr.size(), 0);
    checkOutput("noResumeExec", execCnt, 0);
    applyStimulus(vecs[0]);
    checkOutput("firstWriteAfterReset", (wrAddr.size() > 0) ? wrAddr[0] : -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
